// File: rtl/bin_fc_seq.sv
// Sequential binary-weight fully-connected layer: LANES inputs per cycle into
// OUTPUT_DIM accumulators, then shift+saturate (or sign if BIN_FC_SIGN_ACT_EN).
module bin_fc_seq #(
    parameter int INPUT_DIM  = 16,
    parameter int OUTPUT_DIM = 8,
    parameter int BIT_CNT    = 8,
    parameter int LANES      = 4,
    parameter int SHIFT      = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INPUT_DIM-1:0][BIT_CNT-1:0]      value_in,
    input  logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0]   weight,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]     value_out,
    output logic                                   busy
);

    localparam int ACC_W  = BIT_CNT + $clog2(INPUT_DIM) + 1;
    localparam int K      = INPUT_DIM / LANES;
    localparam int BEAT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(K - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    generate
        if ((INPUT_DIM % LANES) != 0) begin : g_lanes_check
            $error("bin_fc_seq: LANES must divide INPUT_DIM");
        end
    endgenerate

    logic [1:0]                               state;
    logic [BEAT_W-1:0]                        beat_cnt;
    logic [INPUT_DIM-1:0][BIT_CNT-1:0]        x_reg;
    logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0]     w_reg;
    logic signed [ACC_W-1:0]                  acc      [OUTPUT_DIM];
    logic signed [ACC_W-1:0]                  beat_sum [OUTPUT_DIM];
    logic signed [ACC_W-1:0]                  lane_ext [LANES];
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]       result;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state == S_ACCUM) || (state == S_DONE);

    // Latched operands shift down by one beat each cycle, so the current beat
    // always sits in the low LANES elements and no variable indexing is needed.
    genvar gl;
    generate
        for (gl = 0; gl < LANES; gl++) begin : g_lane
            assign lane_ext[gl] = {{(ACC_W-BIT_CNT){x_reg[gl][BIT_CNT-1]}}, x_reg[gl]};
        end
    endgenerate

    always_comb begin
        for (int o = 0; o < OUTPUT_DIM; o++) begin
            beat_sum[o] = '0;
            for (int l = 0; l < LANES; l++) begin
                if (w_reg[o][l]) begin
                    beat_sum[o] = beat_sum[o] + lane_ext[l];
                end else begin
                    beat_sum[o] = beat_sum[o] - lane_ext[l];
                end
            end
        end
    end

`ifdef BIN_FC_SIGN_ACT_EN
    always_comb begin
        for (int o = 0; o < OUTPUT_DIM; o++) begin
            result[o] = acc[o][ACC_W-1] ? {BIT_CNT{1'b1}} : BIT_CNT'(1);
        end
    end
`else
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-BIT_CNT+1){1'b0}}, {(BIT_CNT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-BIT_CNT+1){1'b1}}, {(BIT_CNT-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted [OUTPUT_DIM];

    always_comb begin
        for (int o = 0; o < OUTPUT_DIM; o++) begin
            shifted[o] = acc[o] >>> SHIFT;
            if (shifted[o] > SAT_MAX) begin
                result[o] = SAT_MAX[BIT_CNT-1:0];
            end else if (shifted[o] < SAT_MIN) begin
                result[o] = SAT_MIN[BIT_CNT-1:0];
            end else begin
                result[o] = shifted[o][BIT_CNT-1:0];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            x_reg     <= '0;
            w_reg     <= '0;
            out_valid <= 1'b0;
            value_out <= '0;
            for (int o = 0; o < OUTPUT_DIM; o++) begin
                acc[o] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg    <= value_in;
                        w_reg    <= weight;
                        beat_cnt <= '0;
                        for (int o = 0; o < OUTPUT_DIM; o++) begin
                            acc[o] <= '0;
                        end
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    for (int o = 0; o < OUTPUT_DIM; o++) begin
                        acc[o]   <= acc[o] + beat_sum[o];
                        w_reg[o] <= w_reg[o] >> LANES;
                    end
                    x_reg <= x_reg >> (LANES * BIT_CNT);
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // First DONE cycle registers the result; then hold until taken.
                    if (!out_valid) begin
                        value_out <= result;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
